// File: rtl/mem_fill_arbiter_pkg.sv
// Shared types and geometry for the cache-fill arbiter: FSM state encoding,
// block geometry and the word-address composition helper.
package mem_arb_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int MEM_LATENCY     = 4;
    localparam int BLK_OFF_BITS    = 4;
    localparam int WORD_IDX_BITS   = 3;
    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int BLK_W           = ADDR_W - BLK_OFF_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FILL_IC = 2'b01,
        FILL_DC = 2'b10,
        STORE   = 2'b11
    } arb_state_t;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } owner_t;

    // Words are 16-bit, so the byte address of word idx is {blk, idx, 0}.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [BLK_W-1:0]         blk,
                                                    input logic [WORD_IDX_BITS-1:0] idx);
        return {blk, idx, 1'b0};
    endfunction

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// Client/memory bundle of the fill arbiter. master = arbiter side,
// slave = the caches plus main memory that surround it.
interface mem_fill_arbiter_if;
    import mem_arb_pkg::*;

    logic              ic_miss;
    logic [ADDR_W-1:0] ic_miss_addr;
    logic              dc_miss;
    logic [ADDR_W-1:0] dc_miss_addr;
    logic              dc_wr_req;
    logic [ADDR_W-1:0] dc_wr_addr;
    logic [DATA_W-1:0] dc_wr_data;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_valid;

    logic              ic_busy;
    logic              dc_busy;
    logic              ic_data_valid;
    logic              dc_data_valid;
    logic [DATA_W-1:0] fill_data;
    logic [ADDR_W-1:0] fill_word_addr;
    logic              ic_tag_write;
    logic              dc_tag_write;
    logic              dc_wr_ack;
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;

    modport master (
        input  ic_miss, ic_miss_addr, dc_miss, dc_miss_addr,
               dc_wr_req, dc_wr_addr, dc_wr_data, mem_data_out, mem_data_valid,
        output ic_busy, dc_busy, ic_data_valid, dc_data_valid, fill_data, fill_word_addr,
               ic_tag_write, dc_tag_write, dc_wr_ack, mem_enable, mem_wr, mem_addr, mem_data_in
    );

    modport slave (
        output ic_miss, ic_miss_addr, dc_miss, dc_miss_addr,
               dc_wr_req, dc_wr_addr, dc_wr_data, mem_data_out, mem_data_valid,
        input  ic_busy, dc_busy, ic_data_valid, dc_data_valid, fill_data, fill_word_addr,
               ic_tag_write, dc_tag_write, dc_wr_ack, mem_enable, mem_wr, mem_addr, mem_data_in
    );

endinterface

// File: rtl/mem_fill_arbiter_block_fill_counter.sv
// Issue/receive word counters for one block fill. Both saturate at the last
// word index; issue_done marks that the final read has already gone out.
module block_fill_counter
    import mem_arb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     issue,
    input  logic                     receive,
    output logic [WORD_IDX_BITS-1:0] iss_cnt,
    output logic [WORD_IDX_BITS-1:0] rcv_cnt,
    output logic                     issue_done,
    output logic                     last_word
);
    localparam logic [WORD_IDX_BITS-1:0] CNT_MAX = WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);

    logic [WORD_IDX_BITS-1:0] iss_cnt_reg, iss_cnt_next;
    logic [WORD_IDX_BITS-1:0] rcv_cnt_reg, rcv_cnt_next;
    logic                     issue_done_reg, issue_done_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_cnt_reg    <= '0;
            rcv_cnt_reg    <= '0;
            issue_done_reg <= 1'b0;
        end else begin
            iss_cnt_reg    <= iss_cnt_next;
            rcv_cnt_reg    <= rcv_cnt_next;
            issue_done_reg <= issue_done_next;
        end
    end

    always_comb begin
        iss_cnt_next    = iss_cnt_reg;
        rcv_cnt_next    = rcv_cnt_reg;
        issue_done_next = issue_done_reg;
        if (clear) begin
            iss_cnt_next    = '0;
            rcv_cnt_next    = '0;
            issue_done_next = 1'b0;
        end else begin
            if (issue && !issue_done_reg) begin
                if (iss_cnt_reg == CNT_MAX) issue_done_next = 1'b1;
                else                        iss_cnt_next    = iss_cnt_reg + 1'b1;
            end
            if (receive && (rcv_cnt_reg != CNT_MAX)) rcv_cnt_next = rcv_cnt_reg + 1'b1;
        end
    end

    assign iss_cnt    = iss_cnt_reg;
    assign rcv_cnt    = rcv_cnt_reg;
    assign issue_done = issue_done_reg;
    assign last_word  = receive && (rcv_cnt_reg == CNT_MAX);

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I/D-cache block fills and D-cache stores onto one pipelined memory.
// Optional macro ARB_ROUND_ROBIN_EN alternates contended dc/ic miss grants.
module mem_fill_arbiter
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mem_fill_arbiter_if.master bus
);
    arb_state_t               state_reg, state_next;
    logic [BLK_W-1:0]         blk_reg, blk_next;
    logic                     fill_active;
    logic                     fill_valid;
    logic                     prefer_dc;
    logic                     issue_done;
    logic                     last_word;
    logic [WORD_IDX_BITS-1:0] iss_cnt;
    logic [WORD_IDX_BITS-1:0] rcv_cnt;
    logic [1:0]               client_fill;
    logic [1:0]               client_valid;
    logic [1:0]               client_tag;
    logic                     unused_addr_bits;

    assign fill_active = (state_reg == FILL_IC) || (state_reg == FILL_DC);
    assign fill_valid  = fill_active && bus.mem_data_valid;
    assign client_fill = {state_reg == FILL_DC, state_reg == FILL_IC};

    // Block offset bits of miss addresses are irrelevant: fills always start at word 0.
    assign unused_addr_bits = ^{bus.ic_miss_addr[BLK_OFF_BITS-1:0], bus.dc_miss_addr[BLK_OFF_BITS-1:0]};

    block_fill_counter u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (last_word || !fill_active),
        .issue      (fill_active && !issue_done),
        .receive    (fill_valid),
        .iss_cnt    (iss_cnt),
        .rcv_cnt    (rcv_cnt),
        .issue_done (issue_done),
        .last_word  (last_word)
    );

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_owner_reg, last_owner_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_owner_reg <= OWNER_IC;
        else        last_owner_reg <= last_owner_next;
    end

    // Under contention the client that did not own the previous fill wins.
    assign prefer_dc = !(bus.ic_miss && (last_owner_reg == OWNER_DC));

    always_comb begin
        last_owner_next = last_owner_reg;
        if (state_reg == IDLE) begin
            if (state_next == FILL_DC)      last_owner_next = OWNER_DC;
            else if (state_next == FILL_IC) last_owner_next = OWNER_IC;
        end
    end
`else
    assign prefer_dc = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            blk_reg   <= '0;
        end else begin
            state_reg <= state_next;
            blk_reg   <= blk_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        blk_next   = blk_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.dc_wr_req) begin
                    state_next = STORE;
                end else if (bus.dc_miss && prefer_dc) begin
                    state_next = FILL_DC;
                    blk_next   = bus.dc_miss_addr[ADDR_W-1:BLK_OFF_BITS];
                end else if (bus.ic_miss) begin
                    state_next = FILL_IC;
                    blk_next   = bus.ic_miss_addr[ADDR_W-1:BLK_OFF_BITS];
                end
            end
            FILL_IC, FILL_DC: begin
                if (last_word) state_next = IDLE;
            end
            STORE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_enable  = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_data_in = '0;
        bus.dc_wr_ack   = 1'b0;
        if (state_reg == STORE) begin
            bus.mem_enable  = 1'b1;
            bus.mem_wr      = 1'b1;
            bus.mem_addr    = bus.dc_wr_addr;
            bus.mem_data_in = bus.dc_wr_data;
            bus.dc_wr_ack   = 1'b1;
        end else if (fill_active && !issue_done) begin
            bus.mem_enable = 1'b1;
            bus.mem_addr   = word_addr(blk_reg, iss_cnt);
        end
    end

    assign bus.ic_busy        = (state_reg == FILL_IC);
    assign bus.dc_busy        = (state_reg == FILL_DC) || (state_reg == STORE);
    assign bus.fill_data      = fill_valid ? bus.mem_data_out : '0;
    assign bus.fill_word_addr = fill_valid ? word_addr(blk_reg, rcv_cnt) : '0;

    // Index 0 is the I-cache, index 1 the D-cache.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_client
            assign client_valid[gi] = fill_valid && client_fill[gi];
            assign client_tag[gi]   = last_word && client_fill[gi];
        end
    endgenerate

    assign bus.ic_data_valid = client_valid[0];
    assign bus.dc_data_valid = client_valid[1];
    assign bus.ic_tag_write  = client_tag[0];
    assign bus.dc_tag_write  = client_tag[1];

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Self-checking bench for mem_fill_arbiter: 4-cycle pipelined memory model plus
// a transaction-level schedule of grants, issues and returning words.
module tb_mem_fill_arbiter;
    import mem_arb_pkg::*;

    localparam int K_STORE = 0;
    localparam int K_DC    = 1;
    localparam int K_IC    = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        int          start;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_fill_arbiter_if bus();

    mem_fill_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int          checks = 0;
    int          passed = 0;
    int          cycle  = 0;
    bit          tb_last_dc = 1'b0;
    txn_t        plan_q[$];
    logic        pipe_v [4];
    logic [15:0] pipe_a [4];
    logic        stray_valid = 1'b0;
    logic [15:0] stray_data  = 16'h0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'd7) ^ 16'hC3A5;
    endfunction

    // One clock: memory drives its response at the falling edge, then the
    // access presented by the arbiter this cycle enters the 4-deep pipeline.
    task automatic tick();
        @(negedge clk);
        bus.mem_data_valid = pipe_v[3] | stray_valid;
        bus.mem_data_out   = pipe_v[3] ? mem_word(pipe_a[3]) : (stray_valid ? stray_data : 16'h0);
        for (int i = 3; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_a[i] = pipe_a[i-1];
        end
        #1;
        pipe_v[0] = bus.mem_enable && !bus.mem_wr;
        pipe_a[0] = bus.mem_addr;
        cycle++;
    endtask

    // Expected grant order from the arbitration rules.
    task automatic plan_txns(input bit wr, input bit dcm, input bit icm,
                             input logic [15:0] wa, input logic [15:0] wd,
                             input logic [15:0] da, input logic [15:0] ia);
        bit dc_first;
        plan_q.delete();
        if (wr) plan_q.push_back('{kind: K_STORE, addr: wa, data: wd, start: 0});
        dc_first = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        if (dcm && icm && tb_last_dc) dc_first = 1'b0;
`endif
        if (dcm && dc_first)  plan_q.push_back('{kind: K_DC, addr: da, data: 16'h0, start: 0});
        if (icm)              plan_q.push_back('{kind: K_IC, addr: ia, data: 16'h0, start: 0});
        if (dcm && !dc_first) plan_q.push_back('{kind: K_DC, addr: da, data: 16'h0, start: 0});
        foreach (plan_q[i]) if (plan_q[i].kind != K_STORE) tb_last_dc = (plan_q[i].kind == K_DC);
    endtask

    // Raise the planned requests together, then check every cycle against the
    // schedule: grant cycle, 1-cycle store or 8 issues + 8 returns 4 later.
    task automatic run_plan(input int drop_dc_at);
        int s, t_end, d, k;
        bit e_en, e_wr, e_icb, e_dcb, e_icv, e_dcv, e_ict, e_dct, e_ack;
        logic [15:0] e_maddr, e_din, e_fdata, e_faddr, a;
        s = 1;
        foreach (plan_q[i]) begin
            plan_q[i].start = s;
            s += (plan_q[i].kind == K_STORE) ? 2 : 13;
        end
        t_end = s;
        for (int c = 0; c <= t_end; c++) begin
            tick();
            {e_en, e_wr, e_icb, e_dcb, e_icv, e_dcv, e_ict, e_dct, e_ack} = '0;
            e_maddr = '0; e_din = '0; e_fdata = '0; e_faddr = '0;
            foreach (plan_q[i]) begin
                d = c - plan_q[i].start;
                a = plan_q[i].addr;
                if (plan_q[i].kind == K_STORE) begin
                    if (d == 0) begin
                        e_en = 1; e_wr = 1; e_maddr = a; e_din = plan_q[i].data; e_ack = 1; e_dcb = 1;
                    end
                end else if (d >= 0 && d <= 11) begin
                    if (plan_q[i].kind == K_DC) e_dcb = 1; else e_icb = 1;
                    if (d <= 7) begin
                        e_en = 1;
                        e_maddr = {a[15:4], 4'(2 * d)};
                    end
                    if (d >= 4) begin
                        k = d - 4;
                        e_faddr = {a[15:4], 4'(2 * k)};
                        e_fdata = mem_word(e_faddr);
                        if (plan_q[i].kind == K_DC) begin e_dcv = 1; e_dct = (k == 7); end
                        else                        begin e_icv = 1; e_ict = (k == 7); end
                    end
                end
            end
            checks++;
            if ({bus.mem_enable, bus.mem_wr} !== {e_en, e_wr})
                $display("FAIL mem_strobe cyc=%0d got en/wr=%b%b exp=%b%b", c, bus.mem_enable, bus.mem_wr, e_en, e_wr);
            else passed++;
            if (e_en) begin
                checks++;
                if (bus.mem_addr !== e_maddr)
                    $display("FAIL mem_addr cyc=%0d got=%h exp=%h", c, bus.mem_addr, e_maddr);
                else passed++;
            end
            if (e_wr) begin
                checks++;
                if (bus.mem_data_in !== e_din)
                    $display("FAIL mem_data_in cyc=%0d got=%h exp=%h", c, bus.mem_data_in, e_din);
                else passed++;
            end
            checks++;
            if ({bus.ic_busy, bus.dc_busy} !== {e_icb, e_dcb})
                $display("FAIL busy cyc=%0d got ic/dc=%b%b exp=%b%b", c, bus.ic_busy, bus.dc_busy, e_icb, e_dcb);
            else passed++;
            checks++;
            if ({bus.ic_data_valid, bus.dc_data_valid, bus.ic_tag_write, bus.dc_tag_write, bus.dc_wr_ack}
                !== {e_icv, e_dcv, e_ict, e_dct, e_ack})
                $display("FAIL pulses cyc=%0d got icv,dcv,ict,dct,ack=%b exp=%b", c,
                         {bus.ic_data_valid, bus.dc_data_valid, bus.ic_tag_write, bus.dc_tag_write, bus.dc_wr_ack},
                         {e_icv, e_dcv, e_ict, e_dct, e_ack});
            else passed++;
            if (e_icv || e_dcv) begin
                checks++;
                if ({bus.fill_data, bus.fill_word_addr} !== {e_fdata, e_faddr})
                    $display("FAIL fill_word cyc=%0d got data=%h addr=%h exp data=%h addr=%h", c,
                             bus.fill_data, bus.fill_word_addr, e_fdata, e_faddr);
                else passed++;
            end
            // Inputs for the next cycle: raise requests at cycle 0, drop when served.
            if (c == 0) begin
                foreach (plan_q[i]) begin
                    case (plan_q[i].kind)
                        K_STORE: begin bus.dc_wr_req = 1; bus.dc_wr_addr = plan_q[i].addr; bus.dc_wr_data = plan_q[i].data; end
                        K_DC:    begin bus.dc_miss = 1; bus.dc_miss_addr = plan_q[i].addr; end
                        default: begin bus.ic_miss = 1; bus.ic_miss_addr = plan_q[i].addr; end
                    endcase
                end
            end
            foreach (plan_q[i]) begin
                if (plan_q[i].kind == K_STORE && c == plan_q[i].start) bus.dc_wr_req = 0;
                if (plan_q[i].kind == K_DC && c == plan_q[i].start + 11) bus.dc_miss = 0;
                if (plan_q[i].kind == K_IC && c == plan_q[i].start + 11) bus.ic_miss = 0;
            end
            if (c == drop_dc_at) bus.dc_miss = 0;
        end
    endtask

    task automatic test_reset();
        logic [72:0] outs;
        tick();
        tick();
        outs = {bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.ic_busy, bus.dc_busy,
                bus.ic_data_valid, bus.dc_data_valid, bus.fill_data, bus.fill_word_addr,
                bus.ic_tag_write, bus.dc_tag_write, bus.dc_wr_ack};
        checks++;
        if (outs !== '0) $display("FAIL reset_outputs got=%h exp=0", outs);
        else passed++;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.mem_enable, bus.ic_busy, bus.dc_busy, bus.dc_wr_ack} !== 4'b0)
            $display("FAIL idle_after_reset got=%b exp=0000", {bus.mem_enable, bus.ic_busy, bus.dc_busy, bus.dc_wr_ack});
        else passed++;
    endtask

    task automatic test_ic_fill();
        plan_txns(0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h1234);
        run_plan(-1);
    endtask

    task automatic test_contention();
        plan_txns(0, 1, 1, 16'h0, 16'h0, 16'h8000, 16'h4560);
        run_plan(-1);
        plan_txns(0, 1, 0, 16'h0, 16'h0, 16'h2220, 16'h0);
        run_plan(-1);
        plan_txns(0, 1, 1, 16'h0, 16'h0, 16'h9A00, 16'h7F10);
        run_plan(-1);
    endtask

    task automatic test_store_priority();
        plan_txns(1, 0, 1, 16'h0040, 16'hBEEF, 16'h0, 16'(($urandom)));
        run_plan(-1);
    endtask

    task automatic test_drop_mid_fill();
        plan_txns(0, 1, 0, 16'h0, 16'h0, 16'($urandom), 16'h0);
        run_plan(2);
    endtask

    task automatic test_reset_mid_fill();
        int n;
        logic [72:0] outs;
        n = 0;
        bus.ic_miss = 1; bus.ic_miss_addr = 16'($urandom);
        for (int c = 0; c < 40 && n < 3; c++) begin
            tick();
            if (bus.ic_data_valid) n++;
        end
        checks++;
        if (n != 3) $display("FAIL reset_mid_fill_words got=%0d exp=3", n);
        else passed++;
        rst_n = 1'b0;
        bus.ic_miss = 0;
        #1;
        outs = {bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.ic_busy, bus.dc_busy,
                bus.ic_data_valid, bus.dc_data_valid, bus.fill_data, bus.fill_word_addr,
                bus.ic_tag_write, bus.dc_tag_write, bus.dc_wr_ack};
        checks++;
        if (outs !== '0) $display("FAIL reset_mid_fill_outputs got=%h exp=0", outs);
        else passed++;
        tick();
        tick();
        rst_n = 1'b1;
        tb_last_dc = 1'b0;
        for (int c = 0; c < 6; c++) begin
            stray_valid = (c == 4);
            stray_data  = 16'($urandom);
            tick();
            checks++;
            if ({bus.ic_data_valid, bus.dc_data_valid, bus.ic_tag_write, bus.ic_busy} !== 4'b0)
                $display("FAIL inflight_after_reset cyc=%0d got icv,dcv,ict,icb=%b exp=0000", c,
                         {bus.ic_data_valid, bus.dc_data_valid, bus.ic_tag_write, bus.ic_busy});
            else passed++;
        end
        stray_valid = 1'b0;
        plan_txns(0, 0, 1, 16'h0, 16'h0, 16'h0, 16'($urandom));
        run_plan(-1);
    endtask

    task automatic test_stray_idle();
        stray_valid = 1'b1;
        stray_data  = 16'($urandom);
        tick();
        stray_valid = 1'b0;
        checks++;
        if ({bus.ic_data_valid, bus.dc_data_valid, bus.ic_tag_write, bus.dc_tag_write} !== 4'b0)
            $display("FAIL stray_idle got icv,dcv,ict,dct=%b exp=0000",
                     {bus.ic_data_valid, bus.dc_data_valid, bus.ic_tag_write, bus.dc_tag_write});
        else passed++;
    endtask

    task automatic test_random_traffic();
        int sel;
        for (int r = 0; r < 20; r++) begin
            sel = int'($urandom_range(1, 7));
            plan_txns(sel[2], sel[1], sel[0], 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            run_plan(-1);
        end
    endtask

    initial begin
        bus.ic_miss = 0; bus.ic_miss_addr = '0;
        bus.dc_miss = 0; bus.dc_miss_addr = '0;
        bus.dc_wr_req = 0; bus.dc_wr_addr = '0; bus.dc_wr_data = '0;
        bus.mem_data_out = '0; bus.mem_data_valid = 0;
        for (int i = 0; i < 4; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = 16'h0;
        end
        test_reset();
        test_ic_fill();
        test_contention();
        test_store_priority();
        test_drop_mid_fill();
        test_reset_mid_fill();
        test_stray_idle();
        test_random_traffic();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
